// File: rtl/serial_pattern_scan_ctrl.sv
// Serializes each accepted word LSB-first through a dual-pattern overlapping detector
// and reports per-word saturating hit counts over a valid/ready result handshake.
module serial_pattern_scan_ctrl #(
    parameter int WORD_W = 8,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_word,
    input  logic [PAT_W-1:0]  pat_a,
    input  logic [PAT_W-1:0]  pat_b,
    output logic              bit_valid,
    output logic              bit_out,
    output logic              hit_a,
    output logic              hit_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count_a,
    output logic [CNT_W-1:0]  count_b
);

    localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam int HIST_W = PAT_W - 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REPORT
    } ScanState;

    ScanState          state;
    ScanState          nextState;

    logic [WORD_W-1:0] wordReg;
    logic [PAT_W-1:0]  patAReg;
    logic [PAT_W-1:0]  patBReg;
    logic [HIST_W-1:0] histReg;
    logic [FILL_W-1:0] fillCnt;
    logic [IDX_W-1:0]  bitIdx;
    logic [CNT_W-1:0]  cntA;
    logic [CNT_W-1:0]  cntB;

    logic [PAT_W-1:0]  window;
    logic              windowFull;
    logic              matchA;
    logic              matchB;
    logic              lastBit;
    logic              accept;

    // The word register shifts right, so the bit under scan is always bit 0.
    assign window     = {histReg, wordReg[0]};
    assign windowFull = (fillCnt >= FILL_W'(PAT_W - 1));
    assign matchA     = windowFull && (window == patAReg);
    assign matchB     = windowFull && (window == patBReg);
    assign lastBit    = (bitIdx == IDX_W'(WORD_W - 1));
    assign accept     = in_valid && in_ready;

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state logic.
    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (in_valid)  nextState = SHIFT;
            SHIFT:   if (lastBit)   nextState = REPORT;
            REPORT:  if (out_ready) nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Outputs are forced to zero while reset is held, even before the first clock edge.
    always_comb begin
        in_ready  = 1'b0;
        bit_valid = 1'b0;
        bit_out   = 1'b0;
        hit_a     = 1'b0;
        hit_b     = 1'b0;
        out_valid = 1'b0;
        count_a   = '0;
        count_b   = '0;
        if (!reset) begin
            count_a = cntA;
            count_b = cntB;
            case (state)
                IDLE: in_ready = 1'b1;
                SHIFT: begin
                    bit_valid = 1'b1;
                    bit_out   = wordReg[0];
                    hit_a     = matchA;
                    hit_b     = matchB;
                end
                REPORT: out_valid = 1'b1;
                default: in_ready = 1'b0;
            endcase
        end
    end

    // Datapath: inputs are captured on accept so upstream may change them freely afterwards.
    always_ff @(posedge clock) begin
        if (reset) begin
            wordReg <= '0;
            patAReg <= '0;
            patBReg <= '0;
            histReg <= '0;
            fillCnt <= '0;
            bitIdx  <= '0;
            cntA    <= '0;
            cntB    <= '0;
        end else if (accept) begin
            wordReg <= in_word;
            patAReg <= pat_a;
            patBReg <= pat_b;
            histReg <= '0;
            fillCnt <= '0;
            bitIdx  <= '0;
            cntA    <= '0;
            cntB    <= '0;
        end else if (state == SHIFT) begin
            wordReg <= wordReg >> 1;
            histReg <= window[HIST_W-1:0];
            bitIdx  <= bitIdx + 1'b1;
            if (fillCnt != FILL_W'(PAT_W)) begin
                fillCnt <= fillCnt + 1'b1;
            end
            if (matchA && (cntA != '1)) begin
                cntA <= cntA + 1'b1;
            end
            if (matchB && (cntB != '1)) begin
                cntB <= cntB + 1'b1;
            end
        end
    end

endmodule
